// File: rtl/prbs4_pkg.sv
// Shared definitions for the 4-bit PRBS (x^4+x^3+1) generator/checker pair.
//   state_e    : checker synchroniser states
//   SEED       : first word of the sequence (also the reset value of the predictor)
//   lfsr4_next : one Fibonacci step of the pattern
package prbs4_pkg;

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } state_e;

    localparam logic [3:0] SEED = 4'b1111;

    function automatic logic [3:0] lfsr4_next(input logic [3:0] q);
        return {q[2:0], q[3] ^ q[2]};
    endfunction

endpackage

// File: rtl/prbs4_checker_if.sv
// Stream and status bundle between a pattern source and prbs4_checker.
//   in_valid, in_data : received pattern word and its qualifier
//   clr_cnt           : synchronous clear of the error count
//   locked, err_pulse,
//   err_cnt, wrap     : checker status outputs
// master = source/monitor side, slave = checker side.
interface prbs4_checker_if #(
    parameter int unsigned CNT_W = 16
);
    logic             in_valid;
    logic [3:0]       in_data;
    logic             clr_cnt;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_cnt;
    logic             wrap;

    modport master (
        output in_valid, in_data, clr_cnt,
        input  locked, err_pulse, err_cnt, wrap
    );

    modport slave (
        input  in_valid, in_data, clr_cnt,
        output locked, err_pulse, err_cnt, wrap
    );
endinterface

// File: rtl/prbs4_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst : clock and synchronous active-high reset
//   inc      : count one event
//   clr      : clear; an event in the same cycle leaves the count at 1
//   count    : current value, sticks at all-ones
module prbs4_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? CNT_W'(1) : '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/prbs4_checker.sv
// Self-synchronising checker for the 4-bit x^4+x^3+1 pattern.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of prbs4_checker_if (stream in, status out)
// HUNT seeds the predictor from the first nonzero word, VERIFY needs LOCK_MATCHES
// consecutive correct predictions, LOCKED flywheels the predictor and counts errors
// until LOSS_ERRORS consecutive mismatches drop lock.
module prbs4_checker
    import prbs4_pkg::*;
#(
    parameter int unsigned LOCK_MATCHES = 4,
    parameter int unsigned LOSS_ERRORS  = 3,
    parameter int unsigned CNT_W        = 16
) (
    input logic            clk,
    input logic            rst,
    prbs4_checker_if.slave bus
);

    localparam int unsigned MW = $clog2(LOCK_MATCHES + 1);
    localparam int unsigned BW = $clog2(LOSS_ERRORS + 1);

    state_e          state_q, state_d;
    logic [3:0]      expected_q, expected_d;
    logic [MW-1:0]   match_cnt_q, match_cnt_d;
    logic [BW-1:0]   bad_run_q, bad_run_d;
    logic            err_pulse_q, wrap_q, wrap_d;
    logic            err_hit;
    logic            match;
    logic [CNT_W-1:0] err_cnt;

    assign match = (bus.in_data == expected_q);

    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        match_cnt_d = match_cnt_q;
        bad_run_d   = bad_run_q;
        err_hit     = 1'b0;
        wrap_d      = 1'b0;
        if (bus.in_valid) begin
            case (state_q)
                HUNT: begin
                    // An all-zero word is the LFSR lock-up state and can never seed.
                    if (bus.in_data != 4'b0000) begin
                        expected_d  = lfsr4_next(bus.in_data);
                        match_cnt_d = '0;
                        state_d     = VERIFY;
                    end
                end
                VERIFY: begin
                    if (match) begin
                        expected_d  = lfsr4_next(bus.in_data);
                        match_cnt_d = match_cnt_q + MW'(1);
                        if (match_cnt_d == MW'(LOCK_MATCHES)) begin
                            state_d   = LOCKED;
                            bad_run_d = '0;
                        end
                    end else if (bus.in_data != 4'b0000) begin
                        expected_d  = lfsr4_next(bus.in_data);
                        match_cnt_d = '0;
                    end else begin
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    // Flywheel: the predictor free-runs and ignores corrupted input.
                    expected_d = lfsr4_next(expected_q);
                    if (match) begin
                        bad_run_d = '0;
                        wrap_d    = (bus.in_data == SEED);
                    end else begin
                        err_hit   = 1'b1;
                        bad_run_d = bad_run_q + BW'(1);
                        if (bad_run_d == BW'(LOSS_ERRORS)) begin
                            state_d = HUNT;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            expected_q  <= SEED;
            match_cnt_q <= '0;
            bad_run_q   <= '0;
            err_pulse_q <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            match_cnt_q <= match_cnt_d;
            bad_run_q   <= bad_run_d;
            err_pulse_q <= err_hit;
            wrap_q      <= wrap_d;
        end
    end

    prbs4_sat_counter #(
        .CNT_W(CNT_W)
    ) u_err_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (err_hit),
        .clr  (bus.clr_cnt),
        .count(err_cnt)
    );

    assign bus.locked    = (state_q == LOCKED);
    assign bus.err_pulse = err_pulse_q;
    assign bus.wrap      = wrap_q;
    assign bus.err_cnt   = err_cnt;

endmodule

// File: tb/tb_prbs4_checker.sv
// Bench for prbs4_checker: two instances (16-bit and 2-bit error counters) share one
// stimulus stream; a sequence-position model predicts every output after every edge.
module tb_prbs4_checker;

    localparam int unsigned LOCK_M = 4;
    localparam int unsigned LOSS_E = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       tv;
    logic       tc;
    logic [3:0] td;

    always #5 clk = ~clk;

    prbs4_checker_if #(.CNT_W(16)) bus16 ();
    prbs4_checker_if #(.CNT_W(2))  bus2 ();

    assign bus16.in_valid = tv;
    assign bus16.in_data  = td;
    assign bus16.clr_cnt  = tc;
    assign bus2.in_valid  = tv;
    assign bus2.in_data   = td;
    assign bus2.clr_cnt   = tc;

    prbs4_checker #(
        .LOCK_MATCHES(LOCK_M),
        .LOSS_ERRORS (LOSS_E),
        .CNT_W       (16)
    ) u_dut16 (
        .clk(clk),
        .rst(rst),
        .bus(bus16)
    );

    prbs4_checker #(
        .LOCK_MATCHES(LOCK_M),
        .LOSS_ERRORS (LOSS_E),
        .CNT_W       (2)
    ) u_dut2 (
        .clk(clk),
        .rst(rst),
        .bus(bus2)
    );

    // The pattern written out as one full period starting at the seed.
    logic [3:0] seq [15] = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9,
                             4'h3, 4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7};

    // Model: mode 0=hunting, 1=verifying, 2=locked; pos = index of last word in seq.
    int m_mode, m_pos, m_cnt, m_bad, m_err16, m_err2;
    bit m_pulse, m_wrap;
    int checks = 0;
    int errors = 0;
    int gpos   = 0;
    int wraps;

    function automatic int idx_of(input logic [3:0] w);
        for (int i = 0; i < 15; i++) begin
            if (seq[i] == w) return i;
        end
        return 0;
    endfunction

    task automatic model_edge();
        bit counted;
        counted = 0;
        if (rst) begin
            m_mode = 0; m_pos = 0; m_cnt = 0; m_bad = 0;
            m_err16 = 0; m_err2 = 0; m_pulse = 0; m_wrap = 0;
            return;
        end
        m_pulse = 0;
        m_wrap  = 0;
        if (tv) begin
            if (m_mode == 0) begin
                if (td != 4'h0) begin
                    m_pos = idx_of(td); m_cnt = 0; m_mode = 1;
                end
            end else if (m_mode == 1) begin
                if (td == seq[(m_pos + 1) % 15]) begin
                    m_pos = (m_pos + 1) % 15;
                    m_cnt++;
                    if (m_cnt == LOCK_M) begin
                        m_mode = 2; m_bad = 0;
                    end
                end else if (td != 4'h0) begin
                    m_pos = idx_of(td); m_cnt = 0;
                end else begin
                    m_mode = 0;
                end
            end else begin
                m_pos = (m_pos + 1) % 15;
                if (td == seq[m_pos]) begin
                    m_bad  = 0;
                    m_wrap = (m_pos == 0);
                end else begin
                    counted = 1; m_pulse = 1; m_bad++;
                    if (m_bad == LOSS_E) m_mode = 0;
                end
            end
        end
        if (tc) begin
            m_err16 = counted ? 1 : 0;
            m_err2  = counted ? 1 : 0;
        end else if (counted) begin
            if (m_err16 < 65535) m_err16++;
            if (m_err2 < 3) m_err2++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("locked",     32'(bus16.locked),    32'(m_mode == 2));
        chk("err_pulse",  32'(bus16.err_pulse), 32'(m_pulse));
        chk("wrap",       32'(bus16.wrap),      32'(m_wrap));
        chk("err_cnt16",  32'(bus16.err_cnt),   32'(m_err16));
        chk("locked_w2",  32'(bus2.locked),     32'(m_mode == 2));
        chk("err_cnt2",   32'(bus2.err_cnt),    32'(m_err2));
    endtask

    task automatic step(input logic v, input logic [3:0] d, input logic c, input logic r);
        tv = v; td = d; tc = c; rst = r;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic send_good(input logic v, input logic c);
        if (v) begin
            step(1'b1, seq[gpos], c, 1'b0);
            gpos = (gpos + 1) % 15;
        end else begin
            step(1'b0, 4'($urandom), c, 1'b0);
        end
    endtask

    task automatic send_bad(input logic [3:0] mask, input logic c);
        step(1'b1, seq[gpos] ^ mask, c, 1'b0);
        gpos = (gpos + 1) % 15;
    endtask

    initial begin
        int r;
        tv = 0; td = 0; tc = 0; rst = 1;

        // Reset state
        step(0, 4'h0, 0, 1);
        step(0, 4'h0, 0, 1);
        chk("rst_locked", 32'(bus16.locked), 0);
        chk("rst_cnt", 32'(bus16.err_cnt), 0);

        // Lock after seed + 4 matches
        gpos = 0;
        for (int i = 0; i < 4; i++) send_good(1, 0);
        chk("lock_not_yet", 32'(bus16.locked), 0);
        send_good(1, 0);
        chk("lock_after5", 32'(bus16.locked), 1);
        send_good(1, 0);

        // Two full periods: one wrap per 1111
        wraps = 0;
        for (int i = 0; i < 30; i++) begin
            send_good(1, 0);
            wraps += int'(bus16.wrap);
        end
        chk("wrap_count", 32'(wraps), 2);

        // One corrupted word (0100 -> 0101), flywheel continues
        while (seq[gpos] != 4'h4) send_good(1, 0);
        send_bad(4'b0001, 0);
        chk("single_pulse", 32'(bus16.err_pulse), 1);
        chk("single_cnt", 32'(bus16.err_cnt), 1);
        chk("single_locked", 32'(bus16.locked), 1);
        for (int i = 0; i < 3; i++) send_good(1, 0);
        chk("flywheel_cnt", 32'(bus16.err_cnt), 1);

        // Three consecutive errors drop lock
        send_bad(4'b0110, 0);
        send_bad(4'b1000, 0);
        chk("loss_not_yet", 32'(bus16.locked), 1);
        send_bad(4'b0011, 0);
        chk("loss_locked", 32'(bus16.locked), 0);
        chk("loss_cnt", 32'(bus16.err_cnt), 4);
        chk("loss_pulse", 32'(bus16.err_pulse), 1);
        for (int i = 0; i < 4; i++) send_good(1, 0);
        chk("relock_not_yet", 32'(bus16.locked), 0);
        send_good(1, 0);
        chk("relock", 32'(bus16.locked), 1);

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 199));
            if (r < 2) step(1'($urandom), 4'($urandom), 1'($urandom), 1);
            else if (r < 32) send_good(0, r < 4);
            else if (r < 40) send_bad(4'($urandom_range(1, 15)), r == 39);
            else if (r < 42) send_bad(seq[gpos], 0);
            else send_good(1, r < 44);
        end

        // Stuck-at-zero never seeds
        step(0, 4'h0, 0, 1);
        for (int i = 0; i < 20; i++) step(1, 4'h0, 0, 0);
        chk("zero_locked", 32'(bus16.locked), 0);
        chk("zero_cnt", 32'(bus16.err_cnt), 0);

        // Gaps in a good stream: lock counted in valid words only
        gpos = 3;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                send_good(0, 0);
                send_good(0, 0);
            end
            if (i == 4) chk("gap_not_yet", 32'(bus16.locked), 0);
            send_good(1, 0);
        end
        chk("gap_lock", 32'(bus16.locked), 1);

        // Saturation of the 2-bit counter, clear-with-error, reset while locked
        step(0, 4'h0, 0, 1);
        for (int i = 0; i < 5; i++) send_good(1, 0);
        for (int i = 0; i < 5; i++) begin
            send_bad(4'b0100, 0);
            send_good(1, 0);
            send_good(1, 0);
        end
        chk("sat_cnt2", 32'(bus2.err_cnt), 3);
        chk("sat_cnt16", 32'(bus16.err_cnt), 5);
        send_bad(4'b0010, 1);
        chk("clr_err_cnt2", 32'(bus2.err_cnt), 1);
        chk("clr_err_cnt16", 32'(bus16.err_cnt), 1);
        send_good(1, 0);
        send_good(1, 1);
        chk("clr_cnt16", 32'(bus16.err_cnt), 0);
        chk("pre_rst_locked", 32'(bus16.locked), 1);
        send_bad(4'b1111, 0);
        step(1, seq[gpos] ^ 4'h1, 0, 1);
        chk("rst_mid_locked", 32'(bus16.locked), 0);
        chk("rst_mid_pulse", 32'(bus16.err_pulse), 0);
        chk("rst_mid_wrap", 32'(bus16.wrap), 0);
        chk("rst_mid_cnt", 32'(bus16.err_cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
